// File: rtl/FPALL_pkg.sv
// Shared FP datapath types plus the alignment shifter level table and level-to-stage helpers.
// Latency: none (types, constants and constant functions only).
// Backpressure: not applicable.
package FPALL_pkg;

   typedef enum logic {
      FP32 = 1'b0,
      FP16 = 1'b1
   } fp_fmt_e;

   // Log-shifter levels, coarsest first; index i shifts by ALIGN_SHIFT_DIST[i].
   localparam int ALIGN_LEVELS = 5;
   localparam int ALIGN_SHIFT_DIST [ALIGN_LEVELS] = '{16, 8, 4, 2, 1};

   // Levels per register stage: ceil(ALIGN_LEVELS / stages).
   function automatic int align_lvls_per_stage(input int stages);
      return (ALIGN_LEVELS + stages - 1) / stages;
   endfunction

   // Register stage that owns level lvl.
   function automatic int align_stage_of_level(input int lvl, input int stages);
      return lvl / align_lvls_per_stage(stages);
   endfunction

   // First level owned by a stage; ALIGN_LEVELS or more means the stage owns none.
   function automatic int align_first_level(input int stage, input int stages);
      return stage * align_lvls_per_stage(stages);
   endfunction

   // Last level owned by a stage (only meaningful when the stage owns levels).
   function automatic int align_last_level(input int stage, input int stages);
      int last;
      last = (stage + 1) * align_lvls_per_stage(stages);
      if (last > ALIGN_LEVELS) last = ALIGN_LEVELS;
      return last - 1;
   endfunction

endpackage

// File: rtl/fp_align_shifter_pipe_level.sv
// One log level of the lane-aware alignment right-shifter: shift by DIST and fold lost bits into sticky.
// Latency: combinational.
// Backpressure: none; the enclosing pipeline stage owns the handshake.
module align_shift_level
   import FPALL_pkg::*;
#(
   parameter int LANE_W = 13,
   parameter int DIST   = 1,
   localparam int W     = 2 * LANE_W
) (
   input  fp_fmt_e       fmt,
   input  logic [W-1:0]  d,
   input  logic          step_h,
   input  logic          step_l,
   input  logic          sticky_h,
   input  logic          sticky_l,
   output logic [W-1:0]  r,
   output logic          r_sticky_h,
   output logic          r_sticky_l
);

   localparam logic [W-1:0]      ONES_W = '1;
   localparam logic [LANE_W-1:0] ONES_L = '1;

   logic [LANE_W-1:0] lane_h;
   logic [LANE_W-1:0] lane_l;
   logic [W-1:0]      full_shift;
   logic              full_lost;
   logic [LANE_W-1:0] h_shift;
   logic              h_lost;
   logic [LANE_W-1:0] l_shift;
   logic              l_lost;

   assign lane_h = d[W-1:LANE_W];
   assign lane_l = d[LANE_W-1:0];

   // A distance at or beyond the width shifts to zero and the mask covers every bit,
   // which gives lane saturation for free.
   assign full_shift = d >> DIST;
   assign full_lost  = |(d & ~(ONES_W << DIST));
   assign h_shift    = lane_h >> DIST;
   assign h_lost     = |(lane_h & ~(ONES_L << DIST));
   assign l_shift    = lane_l >> DIST;
   assign l_lost     = |(lane_l & ~(ONES_L << DIST));

   // Select the whole-word or per-lane shift; the 16 level is a pass-through in FP16.
   always_comb begin
      r          = d;
      r_sticky_h = sticky_h;
      r_sticky_l = sticky_l;
      if (fmt == FP32) begin
         if (step_l) begin
            r          = full_shift;
            r_sticky_l = sticky_l | full_lost;
         end
      end else if (DIST < 16) begin
         if (step_h) begin
            r[W-1:LANE_W] = h_shift;
            r_sticky_h    = sticky_h | h_lost;
         end
         if (step_l) begin
            r[LANE_W-1:0] = l_shift;
            r_sticky_l    = sticky_l | l_lost;
         end
      end
   end

endmodule

// File: rtl/fp_align_shifter_pipe.sv
// Pipelined FP32 / dual-FP16 alignment right-shifter with sticky, levels 16/8/4/2/1 spread over PIPE_STAGES.
// Latency: PIPE_STAGES cycles from acceptance to out_valid; one result per cycle at full rate.
// Backpressure: per-stage valid/ready; a stage advances when empty or when the next advances, in_ready = advance[0].
module fp_align_shifter_pipe
   import FPALL_pkg::*;
#(
   parameter int LANE_W      = 13,
   parameter int PIPE_STAGES = 2,
   parameter int TAG_W       = 4,
   localparam int W          = 2 * LANE_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  fp_fmt_e          in_fmt,
   input  logic [W-1:0]     in_x,
   input  logic [7:0]       in_s,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output fp_fmt_e          out_fmt,
   output logic [W-1:0]     out_r,
   output logic             out_sticky_h,
   output logic             out_sticky_l,
   output logic [TAG_W-1:0] out_tag
);

   // Stage registers.
   logic [PIPE_STAGES-1:0] vld_q;
   fp_fmt_e                fmt_q [PIPE_STAGES];
   logic [W-1:0]           d_q   [PIPE_STAGES];
   logic                   sh_q  [PIPE_STAGES];
   logic                   sl_q  [PIPE_STAGES];
   logic [7:0]             s_q   [PIPE_STAGES];
   logic [TAG_W-1:0]       tag_q [PIPE_STAGES];

   // What each stage sees on its input side (primary inputs for stage 0).
   logic [PIPE_STAGES-1:0] src_vld;
   fp_fmt_e                src_fmt [PIPE_STAGES];
   logic [W-1:0]           src_d   [PIPE_STAGES];
   logic                   src_sh  [PIPE_STAGES];
   logic                   src_sl  [PIPE_STAGES];
   logic [7:0]             src_s   [PIPE_STAGES];
   logic [TAG_W-1:0]       src_tag [PIPE_STAGES];

   // Shifted data and sticky leaving each stage's levels, captured by that stage's register.
   logic [W-1:0]           res_d  [PIPE_STAGES];
   logic                   res_sh [PIPE_STAGES];
   logic                   res_sl [PIPE_STAGES];

   logic [PIPE_STAGES-1:0] adv;

   // Stage inputs: stage 0 takes the primary inputs, later stages the previous register.
   always_comb begin
      src_vld[0] = in_valid;
      src_fmt[0] = in_fmt;
      src_d[0]   = in_x;
      src_sh[0]  = 1'b0;
      src_sl[0]  = 1'b0;
      src_s[0]   = in_s;
      src_tag[0] = in_tag;
      for (int k = 1; k < PIPE_STAGES; k++) begin
         src_vld[k] = vld_q[k-1];
         src_fmt[k] = fmt_q[k-1];
         src_d[k]   = d_q[k-1];
         src_sh[k]  = sh_q[k-1];
         src_sl[k]  = sl_q[k-1];
         src_s[k]   = s_q[k-1];
         src_tag[k] = tag_q[k-1];
      end
   end

   // Advance ripples back from out_ready: a stage moves when empty or when its successor moves.
   always_comb begin : adv_chain
      logic down_adv;
      down_adv = out_ready;
      adv      = '0;
      for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
         down_adv = !vld_q[k] || down_adv;
         adv[k]   = down_adv;
      end
   end

   assign in_ready = adv[0];

   // Shift levels, each reading fmt and shift amount from the stage that owns it.
   for (genvar i = 0; i < ALIGN_LEVELS; i++) begin : g_lvl
      localparam int ST = align_stage_of_level(i, PIPE_STAGES);
      localparam int BP = ALIGN_LEVELS - 1 - i;

      logic [W-1:0] d_in;
      logic         sh_in;
      logic         sl_in;
      logic [W-1:0] d_out;
      logic         sh_out;
      logic         sl_out;
      logic         step_h;
      logic         step_l;

      if (i == align_first_level(ST, PIPE_STAGES)) begin : g_head
         assign d_in  = src_d[ST];
         assign sh_in = src_sh[ST];
         assign sl_in = src_sl[ST];
      end else begin : g_link
         assign d_in  = g_lvl[i-1].d_out;
         assign sh_in = g_lvl[i-1].sh_out;
         assign sl_in = g_lvl[i-1].sl_out;
      end

      // FP32 uses in_s[4:0]; FP16 uses in_s[7:4] for the hi lane and in_s[3:0] for the lo lane.
      if (BP < 4) begin : g_step
         assign step_h = (src_fmt[ST] == FP16) && src_s[ST][BP+4];
         assign step_l = src_s[ST][BP];
      end else begin : g_step16
         assign step_h = 1'b0;
         assign step_l = (src_fmt[ST] == FP32) && src_s[ST][BP];
      end

      align_shift_level #(
         .LANE_W (LANE_W),
         .DIST   (ALIGN_SHIFT_DIST[i])
      ) u_level (
         .fmt        (src_fmt[ST]),
         .d          (d_in),
         .step_h     (step_h),
         .step_l     (step_l),
         .sticky_h   (sh_in),
         .sticky_l   (sl_in),
         .r          (d_out),
         .r_sticky_h (sh_out),
         .r_sticky_l (sl_out)
      );

      if (i == align_last_level(ST, PIPE_STAGES)) begin : g_tail
         assign res_d[ST]  = d_out;
         assign res_sh[ST] = sh_out;
         assign res_sl[ST] = sl_out;
      end
   end

   // Stages that own no level (deep pipelines) just retime their input.
   for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
      if (align_first_level(k, PIPE_STAGES) >= ALIGN_LEVELS) begin : g_pass
         assign res_d[k]  = src_d[k];
         assign res_sh[k] = src_sh[k];
         assign res_sl[k] = src_sl[k];
      end
   end

   // Stage registers: load on advance; payload only updates for a real transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int k = 0; k < PIPE_STAGES; k++) begin
            fmt_q[k] <= FP32;
            d_q[k]   <= '0;
            sh_q[k]  <= 1'b0;
            sl_q[k]  <= 1'b0;
            s_q[k]   <= '0;
            tag_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < PIPE_STAGES; k++) begin
            if (adv[k]) begin
               vld_q[k] <= src_vld[k];
               if (src_vld[k]) begin
                  fmt_q[k] <= src_fmt[k];
                  d_q[k]   <= res_d[k];
                  sh_q[k]  <= res_sh[k];
                  sl_q[k]  <= res_sl[k];
                  s_q[k]   <= src_s[k];
                  tag_q[k] <= src_tag[k];
               end
            end
         end
      end
   end

   assign out_valid    = vld_q[PIPE_STAGES-1];
   assign out_fmt      = fmt_q[PIPE_STAGES-1];
   assign out_r        = d_q[PIPE_STAGES-1];
   assign out_sticky_h = sh_q[PIPE_STAGES-1];
   assign out_sticky_l = sl_q[PIPE_STAGES-1];
   assign out_tag      = tag_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_fp_align_shifter_pipe.sv
// Self-checking bench for fp_align_shifter_pipe: directed steps plus a scoreboard fed by a reference model.
// Latency: checks the PIPE_STAGES-cycle acceptance-to-output latency.
// Backpressure: exercises a stalled output, in-order drain, full rate and mid-flight reset.
module tb_fp_align_shifter_pipe;
   import FPALL_pkg::*;

   localparam int LANE_W      = 13;
   localparam int PIPE_STAGES = 2;
   localparam int TAG_W       = 4;
   localparam int W           = 2 * LANE_W;

   typedef struct packed {
      fp_fmt_e          fmt;
      logic [W-1:0]     r;
      logic             sh;
      logic             sl;
      logic [TAG_W-1:0] tag;
   } res_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   fp_fmt_e          in_fmt;
   logic [W-1:0]     in_x;
   logic [7:0]       in_s;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   fp_fmt_e          out_fmt;
   logic [W-1:0]     out_r;
   logic             out_sticky_h;
   logic             out_sticky_l;
   logic [TAG_W-1:0] out_tag;

   int n_pass  = 0;
   int n_total = 0;

   res_t             sb[$];
   logic [TAG_W-1:0] drained_tags[$];

   always #5 clk = ~clk;

   fp_align_shifter_pipe #(
      .LANE_W      (LANE_W),
      .PIPE_STAGES (PIPE_STAGES),
      .TAG_W       (TAG_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_fmt       (in_fmt),
      .in_x         (in_x),
      .in_s         (in_s),
      .in_tag       (in_tag),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_fmt      (out_fmt),
      .out_r        (out_r),
      .out_sticky_h (out_sticky_h),
      .out_sticky_l (out_sticky_l),
      .out_tag      (out_tag)
   );

   task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
   endtask

   // Reference: shift each lane via 64-bit arithmetic, sticky from an explicit low-bit mask.
   function automatic res_t model(input fp_fmt_e f, input logic [W-1:0] x,
                                  input logic [7:0] s, input logic [TAG_W-1:0] t);
      res_t        e;
      logic [63:0] v;
      logic [63:0] m;
      int unsigned n;
      e     = '0;
      e.fmt = f;
      e.tag = t;
      if (f == FP32) begin
         n    = 32'(s[4:0]);
         v    = 64'(x);
         m    = (64'd1 << n) - 64'd1;
         e.r  = W'(v >> n);
         e.sl = |(v & m);
      end else begin
         n                = 32'(s[7:4]);
         v                = 64'(x[W-1:LANE_W]);
         m                = (64'd1 << n) - 64'd1;
         e.r[W-1:LANE_W]  = LANE_W'(v >> n);
         e.sh             = |(v & m);
         n                = 32'(s[3:0]);
         v                = 64'(x[LANE_W-1:0]);
         m                = (64'd1 << n) - 64'd1;
         e.r[LANE_W-1:0]  = LANE_W'(v >> n);
         e.sl             = |(v & m);
      end
      return e;
   endfunction

   // Scoreboard: push on input handshake, pop and compare on output handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) sb.push_back(model(in_fmt, in_x, in_s, in_tag));
         if (out_valid && out_ready) begin
            chk("sb_has_entry_on_emit", (sb.size() == 0) ? 64'd1 : 64'd0, 64'd0);
            if (sb.size() != 0) begin
               res_t e;
               e = sb.pop_front();
               chk("sb_result", 64'({out_fmt, out_r, out_sticky_h, out_sticky_l, out_tag}), 64'(e));
            end
            drained_tags.push_back(out_tag);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send(input fp_fmt_e f, input logic [W-1:0] x, input logic [7:0] s,
                       input logic [TAG_W-1:0] t, output int waits);
      in_valid = 1'b1;
      in_fmt   = f;
      in_x     = x;
      in_s     = s;
      in_tag   = t;
      waits    = 0;
      do begin
         @(negedge clk);
         waits++;
      end while (!in_ready && waits < 100);
      if (!in_ready) chk("send_accept_timeout", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input string nm, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 50);
      chk({nm, "_valid"}, 64'(out_valid), 64'd1);
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_drained"}, 64'(sb.size()), 64'd0);
   endtask

   task automatic set_bp(input int t);
      in_tag = TAG_W'(t);
      in_fmt = (t % 2 == 1) ? FP32 : FP16;
      in_x   = 26'h1234567 ^ (W'(t) << 7);
      in_s   = 8'(t * 7);
   endtask

   initial begin
      int               w;
      int               lat;
      int               stall_total;
      int               idx;
      int               n;
      logic             acc_now;
      logic [W-1:0]     held_r;
      logic [TAG_W-1:0] held_tag;
      logic             stale;
      logic [15:0]      order;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_fmt    = FP32;
      in_x      = '0;
      in_s      = '0;
      in_tag    = '0;
      out_ready = 1'b1;

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_r", 64'(out_r), 64'd0);
      chk("rst_sticky", 64'({out_sticky_h, out_sticky_l}), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      chk("rst_out_fmt", 64'(out_fmt), 64'(FP32));
      sync();
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      sync();

      // FP32 basic shift with latency.
      send(FP32, 26'h2000000, 8'd5, 4'h1, w);
      wait_out("fp32_s5", lat);
      chk("latency", 64'(lat), 64'(PIPE_STAGES));
      chk("fp32_s5_r", 64'(out_r), 64'h0100000);
      chk("fp32_s5_sticky", 64'(out_sticky_l), 64'd0);
      sync();

      // FP32 sticky from a single lost bit.
      send(FP32, 26'h0000003, 8'd1, 4'h2, w);
      wait_out("fp32_s1", lat);
      chk("fp32_s1_r", 64'(out_r), 64'h1);
      chk("fp32_s1_sticky", 64'({out_sticky_h, out_sticky_l}), 64'b01);
      sync();

      // FP32 saturation.
      send(FP32, 26'h3FFFFFF, 8'd31, 4'h3, w);
      wait_out("fp32_sat", lat);
      chk("fp32_sat_r", 64'(out_r), 64'd0);
      chk("fp32_sat_sticky", 64'(out_sticky_l), 64'd1);
      sync();

      // FP16 two lanes, no leakage.
      send(FP16, {13'h1000, 13'h0003}, 8'h31, 4'h4, w);
      wait_out("fp16_basic", lat);
      chk("fp16_basic_r", 64'(out_r), 64'({13'h0200, 13'h0001}));
      chk("fp16_basic_sticky", 64'({out_sticky_h, out_sticky_l}), 64'b01);
      chk("fp16_basic_fmt", 64'(out_fmt), 64'(FP16));
      sync();

      // FP16 hi-lane saturation (shift 13 on a 13-bit lane), lo lane untouched.
      send(FP16, {13'h1FFF, 13'h0001}, 8'hD0, 4'h5, w);
      wait_out("fp16_sat", lat);
      chk("fp16_sat_r", 64'(out_r), 64'h1);
      chk("fp16_sat_sticky", 64'({out_sticky_h, out_sticky_l}), 64'b10);
      sync();
      drain("directed");

      // Backpressure: out_ready low for 5 cycles while tags 1..4 are offered.
      drained_tags.delete();
      sync();
      out_ready = 1'b0;
      idx       = 0;
      in_valid  = 1'b1;
      set_bp(1);
      held_r    = '0;
      held_tag  = '0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         acc_now = in_ready;
         if (c == 2) begin
            held_r   = out_r;
            held_tag = out_tag;
         end
         if (c == 4) begin
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_r_stable", 64'(out_r), 64'(held_r));
            chk("bp_tag_stable", 64'(out_tag), 64'(held_tag));
            chk("bp_head_tag", 64'(out_tag), 64'd1);
         end
         @(posedge clk);
         #1;
         if (acc_now) begin
            idx++;
            if (idx < 4) set_bp(idx + 1);
            else in_valid = 1'b0;
         end
      end
      chk("bp_accepted", 64'(idx), 64'd2);
      out_ready = 1'b1;
      n = 0;
      while ((idx < 4 || drained_tags.size() < 4) && n < 50) begin
         @(negedge clk);
         acc_now = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (acc_now) begin
            idx++;
            if (idx < 4) set_bp(idx + 1);
            else in_valid = 1'b0;
         end
         n++;
      end
      order = {drained_tags[0], drained_tags[1], drained_tags[2], drained_tags[3]};
      chk("bp_drain_order", 64'(order), 64'h1234);
      drain("bp");

      // Interleaved formats at full rate.
      sync();
      stall_total = 0;
      send(FP32, 26'h2ABCDEF, 8'd7, 4'h6, w);
      stall_total += w - 1;
      send(FP16, {13'h1A5A, 13'h0F0F}, 8'h5C, 4'h7, w);
      stall_total += w - 1;
      send(FP32, 26'h0000FFF, 8'd12, 4'h8, w);
      stall_total += w - 1;
      for (int i = 0; i < 12; i++) begin
         send(fp_fmt_e'($urandom_range(0, 1)), W'($urandom), 8'($urandom), TAG_W'(i), w);
         stall_total += w - 1;
      end
      chk("full_rate_no_stall", 64'(stall_total), 64'd0);
      drain("interleave");

      // Reset with two transactions in flight.
      sync();
      out_ready = 1'b0;
      send(FP32, 26'h1555555, 8'd3, 4'hA, w);
      send(FP16, {13'h0ABC, 13'h1DEF}, 8'h22, 4'hB, w);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      sb.delete();
      sync();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      stale = 1'b0;
      for (int c = 0; c < 4; c++) begin
         stale = stale | out_valid;
         @(negedge clk);
      end
      chk("mid_rst_no_stale", 64'(stale), 64'd0);
      sync();
      send(FP32, 26'h3000001, 8'd25, 4'hC, w);
      wait_out("post_rst", lat);
      chk("post_rst_tag", 64'(out_tag), 64'hC);
      chk("post_rst_r", 64'(out_r), 64'h1);
      sync();
      drain("final");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fp_align_shifter_pipe.md
# fp_align_shifter_pipe

Pipelined, parametrised alignment right-shifter with sticky generation for the shared FP32/FP16 datapath. It replaces the single-cycle combinational aligner in the adder front end. It splits the log-shifter levels across a configurable number of register stages. Each stage uses a valid/ready handshake with backpressure. Shift amounts at or above the lane width saturate: the lane result is zero and its sticky bit is the OR of all input lane bits. It sits between exponent-difference computation and the mantissa adder, and carries a user tag alongside each transaction.

## Interface
Parameters:
- LANE_W, 13: FP16 lane width in bits; datapath width W = 2*LANE_W (26 by default). Legal range is 8..16.
- PIPE_STAGES, 2: number of register stages, legal 1..5. The five shift levels (16, 8, 4, 2, 1) are distributed across these stages.
- TAG_W, 4: width of the opaque tag passed through with each transaction.

Ports:
- clk  in  1  clock; every register is rising-edge.
- rst_n  in  1  asynchronous, active-low reset. Assertion is asynchronous; deassertion is synchronised externally.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  stage 0 can accept a transaction this cycle.
- in_fmt  in  fp_fmt_e  FP32 selects one W-bit lane; FP16 selects two LANE_W-bit lanes.
- in_x  in  W  operand to shift.
  - FP32: full W bits.
  - FP16: hi lane in in_x[W-1:LANE_W], lo lane in in_x[LANE_W-1:0].
- in_s  in  8  shift amount.
  - FP32: uses in_s[4:0], range 0..31.
  - FP16: in_s[7:4] is the hi-lane shift, in_s[3:0] is the lo-lane shift.
- in_tag  in  TAG_W  passthrough tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_fmt  out  fp_fmt_e  fmt of the transaction on the output.
- out_r  out  W  shifted result, using the same lane layout as in_x.
- out_sticky_h  out  1  FP16 hi-lane sticky; always 0 in FP32.
- out_sticky_l  out  1  FP32 sticky, or FP16 lo-lane sticky.
- out_tag  out  TAG_W  tag of the transaction on the output.

## Operation
- Shift semantics:
  - Logical right shift per lane, zero-fill from the MSB side.
  - Sticky is the OR of every bit shifted out below bit 0 of the lane.
- Isolation: in FP16, no bit crosses the lane boundary in either direction.
- Saturation:
  - FP32: a shift of W or more gives out_r = 0 and out_sticky_l = |in_x.
  - FP16: a lane shift of LANE_W or more gives that lane = 0 and its sticky = OR of the input lane. Reachable only when LANE_W is below 16.
- Level mapping:
  - Levels are ordered 16, 8, 4, 2, 1.
  - Each stage takes ceil(5/PIPE_STAGES) levels; the last stage takes the remainder.
  - Partial result, partial sticky, fmt, per-lane shift residue and tag are all registered at each stage boundary.
- The shift-by-16 level is active only in FP32. In FP16 it is a pass-through with no sticky contribution.
- Handshake:
  - A transaction transfers on in_valid && in_ready, and on out_valid && out_ready.
  - Stage k advances when it is empty or when stage k+1 advances. The last stage advances when out_ready is high.
  - in_ready = !valid[0] || advance[0]. This is a combinational path from out_ready, which is accepted.
  - Full throughput: one transaction per cycle while out_ready stays high.
- Stall: while out_valid && !out_ready, out_r, out_sticky_*, out_fmt and out_tag hold stable. Upstream stages fill up, and in_ready falls once stage 0 is occupied and cannot advance.
- Mixed formats: FP32 and FP16 transactions may interleave back to back. Each stage uses the fmt registered with its own data.

## Timing
- Latency is exactly PIPE_STAGES cycles from input acceptance to out_valid, assuming no stall.
- Capacity is PIPE_STAGES transactions in flight. Ordering is strictly in order.
- Reset values: all stage valid bits are 0, and all data, sticky, fmt (FP32) and tag registers are 0. Therefore out_valid = 0, out_r = 0, both sticky outputs are 0, and out_tag = 0. in_ready is 1 from the first cycle after deassertion.
- Reset assertion mid-operation drops every in-flight transaction immediately, with no flush cycle.
- Simultaneous accept and emit with a full pipeline behaves as a pure shift: occupancy is unchanged.

## Structure
- The existing FPALL_pkg provides fp_fmt_e. Add the constant ALIGN_LEVELS = 5 and the shift-level table there.
- Sub-module align_shift_level:
  - Combinational, one log level parametrised by shift distance.
  - Inputs: fmt, W-bit data, two lane step bits, and incoming sticky bits.
  - Outputs: shifted data and updated sticky bits.
  - The top module instantiates five of these and places registers according to PIPE_STAGES.

## Test plan
- FP32, in_x = 26'h2000000, in_s = 5 → out_r = 26'h0100000, out_sticky_l = 0, out_valid exactly PIPE_STAGES cycles after acceptance.
- FP32, in_x = 26'h0000003, in_s = 1 → out_r = 26'h0000001, out_sticky_l = 1. Also in_s = 31 with in_x = 26'h3FFFFFF → out_r = 0, out_sticky_l = 1 (saturation).
- FP16, in_x = {13'h1000, 13'h0003}, in_s = 8'h31 → out_r = {13'h0200, 13'h0001}, out_sticky_h = 0, out_sticky_l = 1, with no bit leakage between lanes.
- Backpressure with PIPE_STAGES = 2:
  - Stimulus: out_ready low for 5 cycles while four transactions with tags 1..4 are offered back to back.
  - Required: exactly 2 are accepted and in_ready stays low; when out_ready is raised, tags drain in order 1, 2, 3, 4 with outputs stable during the stall.
- Interleaved FP32/FP16/FP32 at full rate with out_ready high → one result per cycle, each matching a reference model.
- Assert rst_n low with 2 transactions in flight → out_valid = 0 in the same cycle; after release, in_ready = 1 and no stale result appears.
